// File: rtl/hazard_fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_if
//   Bundles the ID-stage instruction description, pipeline status inputs and
//   the hazard/forwarding decisions exchanged with hazard_fwd_ctrl.
//
//   master : pipeline side (drives ID fields, fwd_en, branch/memory status;
//            receives selects, stall/flush/freeze and counters)
//   slave  : the controller itself
//
//   fwd_en, id_*, exe_branch_taken, mem_ready : master -> slave
//   sel_src1/2, hazard_stall, flush, freeze,
//   stall_cnt, flush_cnt                       : slave -> master
// ---------------------------------------------------------------------------
interface hazard_fwd_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             fwd_en;
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic [3:0]       id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             exe_branch_taken;
  logic             mem_ready;

  logic [1:0]       sel_src1;
  logic [1:0]       sel_src2;
  logic             hazard_stall;
  logic             flush;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
           id_dest, id_wb_en, id_mem_read, exe_branch_taken, mem_ready,
    input  sel_src1, sel_src2, hazard_stall, flush, freeze,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
           id_dest, id_wb_en, id_mem_read, exe_branch_taken, mem_ready,
    output sel_src1, sel_src2, hazard_stall, flush, freeze,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard detection and operand forwarding control for the 5-stage core.
//   Keeps a tag (register indices, use flags, write/load flags) for the
//   instructions currently in EXE, MEM and WB, and from them derives:
//     - EXE operand mux selects (00 regfile, 01 MEM result, 10 WB result)
//     - load-use / RAW stalls, branch flushes and memory-wait freezes
//     - saturating counters of stall and flush cycles
//
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset; outputs forced to 0 while high
//     bus  : hazard_fwd_ctrl_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
);

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_read;
  } tag_t;

  // A tag produces a value some later reader needs when it is a live,
  // register-writing instruction whose destination equals a source that the
  // reader actually consumes.
  function automatic logic tag_match(tag_t t, logic [3:0] src, logic use_src);
    return t.valid & t.wb_en & (t.dest == src) & use_src;
  endfunction

  tag_t exe_q, exe_d;
  tag_t mem_q, mem_d;
  tag_t wb_q,  wb_d;
  tag_t id_tag;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_hit;
  logic mem_hit;
  logic hazard;
  logic freeze_c;
  logic flush_c;
  logic stall_c;
  logic [1:0] sel1_c;
  logic [1:0] sel2_c;

  // Not every tag field is consumed in every stage (e.g. sources of the WB
  // instruction); keep them in the tag so all stages share one layout.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{exe_q, mem_q, wb_q};

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = bus.id_valid;
    id_tag.src1     = bus.id_src1;
    id_tag.src2     = bus.id_src2;
    id_tag.use1     = bus.id_use_src1;
    id_tag.use2     = bus.id_use_src2;
    id_tag.dest     = bus.id_dest;
    id_tag.wb_en    = bus.id_wb_en;
    id_tag.mem_read = bus.id_mem_read;
  end

  // With forwarding only a load still in EXE cannot supply its data in
  // time. Without forwarding anything not yet in WB blocks the reader; WB is
  // harmless because the register file writes in the first half-cycle.
  always_comb begin
    exe_hit = tag_match(exe_q, bus.id_src1, bus.id_use_src1) |
              tag_match(exe_q, bus.id_src2, bus.id_use_src2);
    mem_hit = tag_match(mem_q, bus.id_src1, bus.id_use_src1) |
              tag_match(mem_q, bus.id_src2, bus.id_use_src2);
    if (bus.fwd_en) begin
      hazard = bus.id_valid & exe_q.mem_read & exe_hit;
    end else begin
      hazard = bus.id_valid & (exe_hit | mem_hit);
    end
  end

  // Memory wait beats a taken branch, which beats a data hazard.
  always_comb begin
    freeze_c = ~bus.mem_ready;
    flush_c  = bus.mem_ready & bus.exe_branch_taken;
    stall_c  = bus.mem_ready & ~bus.exe_branch_taken & hazard;
  end

  // Tag pipeline advance: held on freeze, bubble into EXE on flush or stall.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze_c) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      if (flush_c || stall_c) begin
        exe_d = '0;
      end else begin
        exe_d = id_tag;
      end
    end
  end

  // Counters saturate at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Operand selects come purely from registered tags, so they stay stable
  // through a freeze. The younger MEM result takes precedence over WB.
  always_comb begin
    sel1_c = 2'b00;
    sel2_c = 2'b00;
    if (bus.fwd_en && exe_q.valid) begin
      if (tag_match(mem_q, exe_q.src1, exe_q.use1)) begin
        sel1_c = 2'b01;
      end else if (tag_match(wb_q, exe_q.src1, exe_q.use1)) begin
        sel1_c = 2'b10;
      end
      if (tag_match(mem_q, exe_q.src2, exe_q.use2)) begin
        sel2_c = 2'b01;
      end else if (tag_match(wb_q, exe_q.src2, exe_q.use2)) begin
        sel2_c = 2'b10;
      end
    end
  end

  // Reset masks every output immediately, before the first reset edge.
  always_comb begin
    bus.sel_src1     = rst ? 2'b00 : sel1_c;
    bus.sel_src2     = rst ? 2'b00 : sel2_c;
    bus.hazard_stall = ~rst & stall_c;
    bus.flush        = ~rst & flush_c;
    bus.freeze       = ~rst & freeze_c;
    bus.stall_cnt    = rst ? '0 : stall_cnt_q;
    bus.flush_cnt    = rst ? '0 : flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed bench for hazard_fwd_ctrl. Each table row is one clock cycle of
//   ID/status inputs with the outputs expected before that cycle's edge.
//   Counters use a 4-bit width so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  hazard_fwd_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] dst;
    logic       wb;
    logic       mr;
  } ins_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       fwd;
    ins_t       ins;
    logic       br;
    logic       rdy;
    logic [1:0] e_sel1;
    logic [1:0] e_sel2;
    logic       e_stall;
    logic       e_flush;
    logic       e_freeze;
    int         e_scnt;
    int         e_fcnt;
  } vec_t;

  //                          v   s1     s2     u1  u2  dst    wb  mr
  localparam ins_t NOP    = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
  localparam ins_t ADD_R1 = '{1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
  localparam ins_t SUB_R2 = '{1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0};
  localparam ins_t ORR_R6 = '{1'b1, 4'd1, 4'd7, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0};
  localparam ins_t LDR_R4 = '{1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1};
  localparam ins_t ADD_R5 = '{1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0};
  localparam ins_t MOV_R2 = '{1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0};

  vec_t vecs[$];
  int   pass_cnt;
  int   total_cnt;

  // Bench-side record of which stages hold a load, stepped from the expected
  // control outputs, to check that MEM-stage loads are never forwarded.
  logic sh_exe_ld;
  logic sh_mem_ld;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void addv(input string n, input logic r, input logic f,
                               input ins_t i, input logic b, input logic y,
                               input logic [1:0] e1, input logic [1:0] e2,
                               input logic s, input logic l, input logic z,
                               input int sc, input int fc);
    vec_t v;
    v.name = n; v.rst = r; v.fwd = f; v.ins = i; v.br = b; v.rdy = y;
    v.e_sel1 = e1; v.e_sel2 = e2; v.e_stall = s; v.e_flush = l;
    v.e_freeze = z; v.e_scnt = sc; v.e_fcnt = fc;
    vecs.push_back(v);
  endfunction

  task automatic driveIns(input ins_t i);
    bus.id_valid    = i.v;
    bus.id_src1     = i.s1;
    bus.id_src2     = i.s2;
    bus.id_use_src1 = i.u1;
    bus.id_use_src2 = i.u2;
    bus.id_dest     = i.dst;
    bus.id_wb_en    = i.wb;
    bus.id_mem_read = i.mr;
  endtask

  // Drive one cycle, check before the edge, then step past the edge.
  task automatic applyStimulus(input vec_t v);
    rst                  = v.rst;
    bus.fwd_en           = v.fwd;
    bus.exe_branch_taken = v.br;
    bus.mem_ready        = v.rdy;
    driveIns(v.ins);
    @(negedge clk);
    checkOutput({v.name, "/sel_src1"},     int'(bus.sel_src1),     int'(v.e_sel1));
    checkOutput({v.name, "/sel_src2"},     int'(bus.sel_src2),     int'(v.e_sel2));
    checkOutput({v.name, "/hazard_stall"}, int'(bus.hazard_stall), int'(v.e_stall));
    checkOutput({v.name, "/flush"},        int'(bus.flush),        int'(v.e_flush));
    checkOutput({v.name, "/freeze"},       int'(bus.freeze),       int'(v.e_freeze));
    checkOutput({v.name, "/stall_cnt"},    int'(bus.stall_cnt),    v.e_scnt);
    checkOutput({v.name, "/flush_cnt"},    int'(bus.flush_cnt),    v.e_fcnt);
    if (sh_mem_ld && v.fwd) begin
      checkOutput({v.name, "/no_sel01_vs_mem_load"},
                  int'((bus.sel_src1 == 2'b01) || (bus.sel_src2 == 2'b01)), 0);
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      sh_exe_ld = 1'b0;
      sh_mem_ld = 1'b0;
    end else if (!v.e_freeze) begin
      sh_mem_ld = sh_exe_ld;
      sh_exe_ld = (v.e_stall || v.e_flush) ? 1'b0 : (v.ins.v & v.ins.mr);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    sh_exe_ld = 1'b0;
    sh_mem_ld = 1'b0;

    // ALU chain with forwarding: MEM forward, then WB forward.
    addv("alu_c0", 0, 1, ADD_R1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("alu_c1", 0, 1, SUB_R2, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("alu_c2", 0, 1, ORR_R6, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    addv("alu_c3", 0, 1, NOP,    0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    addv("alu_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("alu_c5", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // Load-use: one stall, then both operands from WB.
    addv("ldu_c0", 0, 1, LDR_R4, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("ldu_c1", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    addv("ldu_c2", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    addv("ldu_c3", 0, 1, NOP,    0, 1, 2'b10, 2'b10, 0, 0, 0, 1, 0);
    addv("ldu_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    addv("ldu_c5", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    // Stall-only mode: RAW on an ALU result stalls two cycles.
    addv("nofwd_c0", 0, 0, ADD_R1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    addv("nofwd_c1", 0, 0, MOV_R2, 0, 1, 2'b00, 2'b00, 1, 0, 0, 1, 0);
    addv("nofwd_c2", 0, 0, MOV_R2, 0, 1, 2'b00, 2'b00, 1, 0, 0, 2, 0);
    addv("nofwd_c3", 0, 0, MOV_R2, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("nofwd_c4", 0, 0, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("nofwd_c5", 0, 0, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("nofwd_c6", 0, 0, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    // Dropping fwd_en kills a pending MEM forward in the same cycle.
    addv("fwdoff_c0", 0, 1, ADD_R1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("fwdoff_c1", 0, 1, SUB_R2, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("fwdoff_c2", 0, 0, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("fwdoff_c3", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("fwdoff_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    // Taken branch overrides a simultaneous load-use hazard.
    addv("br_c0", 0, 1, LDR_R4, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 0);
    addv("br_c1", 0, 1, ADD_R5, 1, 1, 2'b00, 2'b00, 0, 1, 0, 3, 0);
    addv("br_c2", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 1);
    addv("br_c3", 0, 1, NOP,    0, 1, 2'b10, 2'b10, 0, 0, 0, 3, 1);
    addv("br_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 1);
    addv("br_c5", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 1);
    // Memory wait during a load-use stall, and during a WB forward.
    addv("frz_c0", 0, 1, LDR_R4, 0, 1, 2'b00, 2'b00, 0, 0, 0, 3, 1);
    addv("frz_c1", 0, 1, ADD_R5, 0, 0, 2'b00, 2'b00, 0, 0, 1, 3, 1);
    addv("frz_c2", 0, 1, ADD_R5, 1, 0, 2'b00, 2'b00, 0, 0, 1, 3, 1);
    addv("frz_c3", 0, 1, ADD_R5, 0, 0, 2'b00, 2'b00, 0, 0, 1, 3, 1);
    addv("frz_c4", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 1, 0, 0, 3, 1);
    addv("frz_c5", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4, 1);
    addv("frz_c6", 0, 1, NOP,    0, 0, 2'b10, 2'b10, 0, 0, 1, 4, 1);
    addv("frz_c7", 0, 1, NOP,    0, 1, 2'b10, 2'b10, 0, 0, 0, 4, 1);
    addv("frz_c8", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 4, 1);
    addv("frz_c9", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 4, 1);
    // Reset in the middle of a stall clears tags and counters.
    addv("rstst_c0", 0, 1, LDR_R4, 0, 1, 2'b00, 2'b00, 0, 0, 0, 4, 1);
    addv("rstst_c1", 1, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstst_c2", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstst_c3", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstst_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstst_c5", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    // Reset in the middle of a freeze.
    addv("rstfz_c0", 0, 1, LDR_R4, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstfz_c1", 0, 1, ADD_R5, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    addv("rstfz_c2", 1, 1, ADD_R5, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstfz_c3", 0, 1, ADD_R5, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstfz_c4", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstfz_c5", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    addv("rstfz_c6", 0, 1, NOP,    0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Reset with random inputs: every output must read 0.
    #1;
    for (int c = 0; c < 2; c++) begin
      rst                  = 1'b1;
      bus.fwd_en           = 1'($urandom);
      bus.exe_branch_taken = 1'($urandom);
      bus.mem_ready        = 1'($urandom);
      driveIns(ins_t'($urandom));
      @(negedge clk);
      checkOutput("reset/sel_src1",     int'(bus.sel_src1),     0);
      checkOutput("reset/sel_src2",     int'(bus.sel_src2),     0);
      checkOutput("reset/hazard_stall", int'(bus.hazard_stall), 0);
      checkOutput("reset/flush",        int'(bus.flush),        0);
      checkOutput("reset/freeze",       int'(bus.freeze),       0);
      checkOutput("reset/stall_cnt",    int'(bus.stall_cnt),    0);
      checkOutput("reset/flush_cnt",    int'(bus.flush_cnt),    0);
      @(posedge clk);
      #1;
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

    // Flush counter saturates at all-ones (15 for a 4-bit counter).
    rst                  = 1'b0;
    bus.fwd_en           = 1'b1;
    bus.mem_ready        = 1'b1;
    bus.exe_branch_taken = 1'b1;
    driveIns(NOP);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checkOutput("sat/flush_cnt_at_15", int'(bus.flush_cnt), 15);
      end
      if (k == 19) begin
        checkOutput("sat/flush_cnt_held", int'(bus.flush_cnt), 15);
        checkOutput("sat/flush",          int'(bus.flush),     1);
      end
      @(posedge clk);
      #1;
    end
    bus.exe_branch_taken = 1'b0;
    @(negedge clk);
    checkOutput("sat/flush_cnt_after", int'(bus.flush_cnt), 15);
    checkOutput("sat/flush_off",       int'(bus.flush),     0);
    checkOutput("sat/stall_cnt",       int'(bus.stall_cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage ARM-subset core. It tracks destination/source tags of the instructions in EXE, MEM and WB, and drives the EXE-stage operand-mux selects (sel_src1/sel_src2). It also decides load-use stalls, branch flushes and memory-wait freezes, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode
id_valid  in  1  ID holds a real instruction
id_src1  in  4  Rn index of ID instruction
id_src2  in  4  Rm/Rd(store) index of ID instruction
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
id_dest  in  4  destination index of ID instruction
id_wb_en  in  1  ID instruction writes register file
id_mem_read  in  1  ID instruction is a load
exe_branch_taken  in  1  branch resolved taken in EXE this cycle
mem_ready  in  1  memory stage complete; 0 = SRAM busy
sel_src1  out  2  EXE src1 mux select: 00 regfile, 01 MEM value, 10 WB value
sel_src2  out  2  EXE src2 mux select, same encoding
hazard_stall  out  1  hold PC and IF/ID, insert bubble into ID/EXE
flush  out  1  kill IF/ID contents (bubble into ID/EXE)
freeze  out  1  hold every pipeline register
stall_cnt  out  CNT_W  cycles with hazard_stall=1, saturating
flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- State: three tag registers EXE/MEM/WB, each {valid, src1, src2, use1, use2, dest, wb_en, mem_read}; plus the two counters.
- Reset (rst=1 at edge): all tags valid=0, wb_en=0; counters 0. While rst=1, all outputs 0: sel=00, hazard_stall/flush/freeze=0.
- Match definition: tag T matches source s when T.valid & T.wb_en & T.dest==s & the use flag for s is set.
- Hazard, combinational on ID inputs vs EXE/MEM tags, requires id_valid:
  - fwd_en=1: hazard only if the EXE tag is a load (mem_read) matching id_src1 or id_src2.
  - fwd_en=0: hazard if either the EXE or MEM tag matches either used source.
  - The WB tag never causes a hazard: the register file writes before it reads.
- Priority, evaluated each cycle:
  1. mem_ready=0: freeze=1; hazard_stall=0, flush=0; all tags hold; counters hold.
  2. exe_branch_taken=1: flush=1, hazard_stall=0. Tags shift WB<-MEM<-EXE, and EXE gets a bubble (valid=0). Any simultaneous hazard is ignored.
  3. hazard: hazard_stall=1. Tags shift with a bubble into EXE; the ID instruction is retained upstream.
  4. else: EXE<-ID fields, valid=id_valid; MEM<-EXE; WB<-MEM.
- Forwarding selects, combinational from registered tags:
  - sel_srcN=01 if fwd_en & MEM matches EXE.srcN.
  - else 10 if fwd_en & WB matches EXE.srcN.
  - else 00.
  - MEM has priority over WB. EXE tag must be valid, else 00.
  - With fwd_en=0, sels are always 00.
  - Sels remain driven during freeze, because the tags are frozen too.
- Load-use sequence: the stall bubble puts the load in WB when the dependent instruction reaches EXE, which yields sel=10. A sel=01 against a MEM-stage load never occurs; the bench asserts this.
- Counters:
  - stall_cnt increments on each non-frozen cycle with hazard_stall=1.
  - flush_cnt increments on each flush=1 cycle.
  - Both saturate at all-ones, no wrap.
- rst asserted mid-stall or mid-freeze: next cycle follows the reset state regardless of other inputs.
- fwd_en change takes effect combinationally in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, counters 0.
- ALU chain, fwd_en=1: ADD R1<-..., then SUB R2<-R1,R3 next cycle -> no stall; when SUB is in EXE, sel_src1=01. Third instr using R1 in EXE -> sel_src1=10.
- Load-use: LDR R4, then ADD R5<-R4,R4 -> exactly 1 cycle hazard_stall=1; next EXE cycle sel_src1=sel_src2=10; stall_cnt=1.
- fwd_en=0, ADD R1 then MOV R2<-R1 -> hazard_stall=1 for 2 cycles; sels stay 00; stall_cnt=2.
- Branch taken with a load-use hazard the same cycle -> flush=1, hazard_stall=0, EXE tag bubbled, flush_cnt=1.
- mem_ready=0 for 3 cycles during a load-use stall -> freeze=1, hazard_stall=0, sels constant, counters frozen. On mem_ready=1, the stall completes as in the load-use scenario.
